// File: rtl/sw_seq_feeder_if.sv
// Handshake bundle between the FASTA feeder, its byte source and the scoring array.
// master: byte source / scoring side; slave: sw_seq_feeder.
interface sw_seq_feeder_if #(
    parameter int SCORE_WIDTH = 12,
    parameter int ID_WIDTH    = 8
);
    logic [7:0]             char_in;
    logic                   char_valid;
    logic                   char_ready;
    logic [1:0]             data_out;
    logic                   en_out;
    logic [SCORE_WIDTH-1:0] result_in;
    logic                   vld_in;
    logic [SCORE_WIDTH:0]   score_out;
    logic [ID_WIDTH-1:0]    score_id;
    logic                   score_vld;

    modport master (
        output char_in, char_valid, result_in, vld_in,
        input  char_ready, data_out, en_out, score_out, score_id, score_vld
    );

    modport slave (
        input  char_in, char_valid, result_in, vld_in,
        output char_ready, data_out, en_out, score_out, score_id, score_vld
    );
endinterface

// File: rtl/sw_seq_feeder.sv
// FASTA byte parser feeding 2-bit bases to the scoring array, with result tagging/unbiasing.
// Optional saturating statistics counters when SW_FEEDER_STATS_EN is defined.
module sw_seq_feeder #(
    parameter int SCORE_WIDTH = 12,
    parameter int ZERO        = 2**(SCORE_WIDTH-1),
    parameter int GAP_CYCLES  = 1,
    parameter int MAX_SEQ_LEN = 4095,
    parameter int ID_WIDTH    = 8,
    parameter int ID_DEPTH    = 4
) (
    input  logic           clk,
    input  logic           rst,
    sw_seq_feeder_if.slave bus,
    output logic           trunc_err,
    output logic           id_underflow
`ifdef SW_FEEDER_STATS_EN
    ,
    output logic [31:0]    base_count,
    output logic [15:0]    drop_count
`endif
);

    localparam int LEN_W = $clog2(MAX_SEQ_LEN + 1);
    localparam int PTR_W = (ID_DEPTH > 1) ? $clog2(ID_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [LEN_W-1:0]       MAX_LEN_C  = LEN_W'(MAX_SEQ_LEN);
    localparam logic [GAP_W-1:0]       GAP_LOAD_C = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]       DEPTH_C    = CNT_W'(ID_DEPTH);
    localparam logic [SCORE_WIDTH:0]   ZERO_C     = (SCORE_WIDTH + 1)'(ZERO);

    localparam logic [7:0] LF_C = 8'h0A;
    localparam logic [7:0] CR_C = 8'h0D;
    localparam logic [7:0] GT_C = 8'h3E;

    typedef enum logic [2:0] {
        st_line_start = 3'd0,
        st_header     = 3'd1,
        st_seq        = 3'd2,
        st_end        = 3'd3,
        st_gap        = 3'd4
    } state_t;

    // Clearing bit 5 folds lowercase ASCII letters onto uppercase.
    function automatic logic is_base(input logic [7:0] c);
        logic [7:0] u;
        u = c & 8'hDF;
        case (u)
            8'h41, 8'h43, 8'h47, 8'h54: is_base = 1'b1;
            default:                    is_base = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] encode(input logic [7:0] c);
        logic [7:0] u;
        u = c & 8'hDF;
        case (u)
            8'h54:   encode = 2'b00;
            8'h43:   encode = 2'b01;
            8'h41:   encode = 2'b10;
            8'h47:   encode = 2'b11;
            default: encode = 2'b00;
        endcase
    endfunction

    state_t                 state_r;
    logic [LEN_W-1:0]       len_r;
    logic [GAP_W-1:0]       gap_r;
    logic [ID_WIDTH-1:0]    seq_idx_r;
    logic                   char_ready_r;
    logic                   en_out_r;
    logic [1:0]             data_out_r;
    logic                   trunc_err_r;

    logic [ID_WIDTH-1:0]    mem_r [2**PTR_W];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       cnt_r;

    logic [SCORE_WIDTH:0]   score_out_r;
    logic [ID_WIDTH-1:0]    score_id_r;
    logic                   score_vld_r;
    logic                   id_underflow_r;

    logic                   acc_s;
    logic                   base_s;
    logic [1:0]             code_s;
    logic                   is_lf_s;
    logic                   is_cr_s;
    logic                   is_gt_s;
    logic                   emit_s;
    logic                   over_s;
    logic                   fifo_empty_s;
    logic                   fifo_full_s;
    logic                   push_s;
    logic                   pop_s;
    logic [ID_WIDTH-1:0]    head_s;

    // Byte decode, emit/truncate decisions and FIFO handshake.
    always_comb begin
        acc_s        = bus.char_valid & char_ready_r;
        base_s       = is_base(bus.char_in);
        code_s       = encode(bus.char_in);
        is_lf_s      = (bus.char_in == LF_C);
        is_cr_s      = (bus.char_in == CR_C);
        is_gt_s      = (bus.char_in == GT_C);
        emit_s       = 1'b0;
        over_s       = 1'b0;
        fifo_empty_s = (cnt_r == {CNT_W{1'b0}});
        fifo_full_s  = (cnt_r == DEPTH_C);
        pop_s        = bus.vld_in & ~fifo_empty_s;
        push_s       = (state_r == st_end) & (~fifo_full_s | pop_s);
        head_s       = mem_r[rd_ptr_r];
        if (acc_s && base_s) begin
            if (state_r == st_line_start) begin
                emit_s = 1'b1;
            end else if (state_r == st_seq) begin
                if (len_r < MAX_LEN_C) begin
                    emit_s = 1'b1;
                end else begin
                    over_s = 1'b1;
                end
            end else begin
                emit_s = 1'b0;
            end
        end else begin
            emit_s = 1'b0;
        end
    end

    // Parser FSM; char_ready is registered from the next state so it is low throughout reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= st_line_start;
            len_r        <= '0;
            gap_r        <= '0;
            seq_idx_r    <= '0;
            char_ready_r <= 1'b0;
            en_out_r     <= 1'b0;
            data_out_r   <= 2'b00;
            trunc_err_r  <= 1'b0;
        end else begin
            en_out_r <= emit_s;
            if (emit_s) begin
                data_out_r <= code_s;
            end
            if (over_s) begin
                trunc_err_r <= 1'b1;
            end
            case (state_r)
                st_line_start: begin
                    char_ready_r <= 1'b1;
                    if (acc_s && !is_cr_s && !is_lf_s) begin
                        if (is_gt_s) begin
                            state_r <= st_header;
                        end else begin
                            // A stray non-base opens a sequence that emits nothing yet.
                            state_r <= st_seq;
                            len_r   <= emit_s ? LEN_W'(1) : '0;
                        end
                    end
                end
                st_header: begin
                    char_ready_r <= 1'b1;
                    if (acc_s && is_lf_s) begin
                        state_r <= st_line_start;
                    end
                end
                st_seq: begin
                    if (acc_s && is_lf_s) begin
                        if (len_r != '0) begin
                            state_r      <= st_end;
                            char_ready_r <= 1'b0;
                        end else begin
                            state_r      <= st_line_start;
                            char_ready_r <= 1'b1;
                        end
                    end else begin
                        char_ready_r <= 1'b1;
                        if (emit_s) begin
                            len_r <= len_r + LEN_W'(1);
                        end
                    end
                end
                st_end: begin
                    char_ready_r <= 1'b0;
                    if (push_s) begin
                        seq_idx_r <= seq_idx_r + ID_WIDTH'(1);
                        gap_r     <= GAP_LOAD_C;
                        state_r   <= st_gap;
                    end
                end
                st_gap: begin
                    if (gap_r == '0) begin
                        state_r      <= st_line_start;
                        char_ready_r <= 1'b1;
                    end else begin
                        gap_r        <= gap_r - GAP_W'(1);
                        char_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= st_line_start;
                    char_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // In-flight sequence-ID storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= seq_idx_r;
        end
    end

    // ID FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Result tagging and bias removal.
    always_ff @(posedge clk) begin
        if (!rst) begin
            score_out_r    <= '0;
            score_id_r     <= '0;
            score_vld_r    <= 1'b0;
            id_underflow_r <= 1'b0;
        end else begin
            score_vld_r <= bus.vld_in;
            if (bus.vld_in) begin
                score_out_r <= {bus.result_in[SCORE_WIDTH-1], bus.result_in} + ZERO_C;
                score_id_r  <= fifo_empty_s ? '0 : head_s;
                if (fifo_empty_s) begin
                    id_underflow_r <= 1'b1;
                end
            end
        end
    end

`ifdef SW_FEEDER_STATS_EN
    logic        drop_s;
    logic [31:0] base_cnt_r;
    logic [15:0] drop_cnt_r;

    // Dropped bytes: non-base text outside headers plus bases beyond the length limit.
    always_comb begin
        drop_s = 1'b0;
        if (acc_s && !is_cr_s) begin
            if (state_r == st_line_start) begin
                drop_s = !base_s && !is_gt_s && !is_lf_s;
            end else if (state_r == st_seq) begin
                drop_s = over_s || (!base_s && !is_lf_s);
            end else begin
                drop_s = 1'b0;
            end
        end else begin
            drop_s = 1'b0;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            base_cnt_r <= 32'd0;
            drop_cnt_r <= 16'd0;
        end else begin
            if (emit_s && (base_cnt_r != 32'hFFFF_FFFF)) begin
                base_cnt_r <= base_cnt_r + 32'd1;
            end
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end
    end

    assign base_count = base_cnt_r;
    assign drop_count = drop_cnt_r;
`endif

    assign bus.char_ready = char_ready_r;
    assign bus.data_out   = data_out_r;
    assign bus.en_out     = en_out_r;
    assign bus.score_out  = score_out_r;
    assign bus.score_id   = score_id_r;
    assign bus.score_vld  = score_vld_r;
    assign trunc_err      = trunc_err_r;
    assign id_underflow   = id_underflow_r;

endmodule

// File: tb/tb_sw_seq_feeder.sv
// Self-checking bench for sw_seq_feeder: table of FASTA lines plus hand sequences for
// FIFO stall, result tagging, underflow, ID wrap and mid-sequence reset.
module tb_sw_seq_feeder;
    localparam int SW    = 12;
    localparam int IDW   = 3;
    localparam int GAPC  = 2;
    localparam int MAXL  = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic trunc_err;
    logic id_underflow;
`ifdef SW_FEEDER_STATS_EN
    logic [31:0] base_count;
    logic [15:0] drop_count;
`endif

    always #5 clk = ~clk;

    sw_seq_feeder_if #(.SCORE_WIDTH(SW), .ID_WIDTH(IDW)) bus ();

    sw_seq_feeder #(
        .SCORE_WIDTH(SW),
        .ZERO(2048),
        .GAP_CYCLES(GAPC),
        .MAX_SEQ_LEN(MAXL),
        .ID_WIDTH(IDW),
        .ID_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .trunc_err(trunc_err),
        .id_underflow(id_underflow)
`ifdef SW_FEEDER_STATS_EN
        ,
        .base_count(base_count),
        .drop_count(drop_count)
`endif
    );

    typedef struct {
        string       txt;
        int          nb;
        logic [15:0] codes;
        bit          closes;
        bit          trunc;
    } vec_t;

    vec_t             vecs [7];
    int               checks = 0;
    int               errors = 0;
    logic [1:0]       exp_codes [$];
    logic [IDW-1:0]   exp_ids [$];
    logic [IDW-1:0]   next_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and score any emitted base.
    task automatic tick();
        @(negedge clk);
        if (bus.en_out === 1'b1) begin
            if (exp_codes.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_base: got code %0d with nothing expected", bus.data_out);
            end else begin
                chk("base_code", bus.data_out, exp_codes.pop_front());
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   n;
        bus.char_in    = b;
        bus.char_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            acc = (bus.char_ready === 1'b1);
            tick();
            n++;
        end
        bus.char_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte %0h not accepted, required within 100 cycles", b);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    task automatic count_low(output int cnt);
        cnt = 0;
        while (bus.char_ready !== 1'b1 && cnt < 50) begin
            tick();
            cnt++;
        end
    endtask

    task automatic pulse_vld(input logic [SW-1:0] res, input logic [SW:0] exp_score);
        logic [IDW-1:0] eid;
        eid = (exp_ids.size() == 0) ? '0 : exp_ids.pop_front();
        bus.result_in = res;
        bus.vld_in    = 1'b1;
        tick();
        bus.vld_in = 1'b0;
        chk("score_vld", bus.score_vld, 1'b1);
        chk("score_out", bus.score_out, exp_score);
        chk("score_id", bus.score_id, eid);
        tick();
        chk("score_pulse_end", bus.score_vld, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string          wrap_s [4];
        logic [1:0]     wrap_c [4];
        int             cnt;
        int             hi;

        bus.char_in    = 8'h00;
        bus.char_valid = 1'b0;
        bus.result_in  = '0;
        bus.vld_in     = 1'b0;
        next_id        = '0;

        vecs[0] = '{">s1\n",       0, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{"ACGT\n",      4, 16'h9C00, 1'b1, 1'b0};
        vecs[2] = '{"acNgt\n",     4, 16'h9C00, 1'b1, 1'b0};
        vecs[3] = '{"TgCa\r\n",    4, 16'h3600, 1'b1, 1'b0};
        vecs[4] = '{">h2 ACGT\n",  0, 16'h0000, 1'b0, 1'b0};
        vecs[5] = '{"N\n",         0, 16'h0000, 1'b0, 1'b0};
        vecs[6] = '{"ACGTAC\n",    4, 16'h9C00, 1'b1, 1'b1};

        repeat (3) tick();
        chk("rst_char_ready", bus.char_ready, 1'b0);
        chk("rst_en_out", bus.en_out, 1'b0);
        chk("rst_data_out", bus.data_out, 2'b00);
        chk("rst_score_vld", bus.score_vld, 1'b0);
        chk("rst_score_out", bus.score_out, 13'd0);
        chk("rst_trunc_err", trunc_err, 1'b0);
        chk("rst_id_underflow", id_underflow, 1'b0);
        rst = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < vecs[v].nb; k++) begin
                exp_codes.push_back(vecs[v].codes[15-2*k -: 2]);
            end
            if (vecs[v].closes) begin
                exp_ids.push_back(next_id);
                next_id = next_id + 3'd1;
            end
            send_str(vecs[v].txt);
            count_low(cnt);
            chk($sformatf("gap_len[%0d]", v), cnt, vecs[v].closes ? 1 + GAPC : 0);
            chk($sformatf("trunc_err[%0d]", v), trunc_err, vecs[v].trunc);
            chk($sformatf("bases_left[%0d]", v), exp_codes.size(), 0);
        end

        // Fifth sequence with four IDs outstanding stalls in END until a result pops one.
        exp_codes.push_back(2'b11);
        exp_codes.push_back(2'b11);
        exp_ids.push_back(next_id);
        next_id = next_id + 3'd1;
        send_str("GG\n");
        hi = 0;
        repeat (8) begin
            if (bus.char_ready === 1'b1) hi++;
            tick();
        end
        chk("stall_ready_cycles", hi, 0);
        pulse_vld(12'h005, 13'd2053);
        count_low(cnt);
        chk("stall_release", cnt, 1);

        pulse_vld(12'hFFF, 13'd2047);
        pulse_vld(12'h800, 13'd0);
        pulse_vld(12'h7FF, 13'd4095);
        pulse_vld(12'h123, 13'd2339);
        chk("no_underflow", id_underflow, 1'b0);
        pulse_vld(12'h001, 13'd2049);
        chk("id_underflow", id_underflow, 1'b1);

        // IDs 5,6,7 then wrap to 0.
        wrap_s = '{"C\n", "G\n", "T\n", "A\n"};
        wrap_c = '{2'b01, 2'b11, 2'b00, 2'b10};
        for (int w = 0; w < 4; w++) begin
            exp_codes.push_back(wrap_c[w]);
            exp_ids.push_back(next_id);
            next_id = next_id + 3'd1;
            send_str(wrap_s[w]);
        end
        count_low(cnt);
        for (int w = 0; w < 4; w++) begin
            pulse_vld(12'h000, 13'd2048);
        end

        // Reset in the middle of a sequence.
        exp_codes.push_back(2'b10);
        exp_codes.push_back(2'b01);
        send_str(">x\n");
        send_byte(8'h41);
        send_byte(8'h43);
        rst = 1'b0;
        tick();
        chk("midrst_en_out", bus.en_out, 1'b0);
        chk("midrst_char_ready", bus.char_ready, 1'b0);
        tick();
        chk("midrst_trunc_err", trunc_err, 1'b0);
        chk("midrst_id_underflow", id_underflow, 1'b0);
        chk("midrst_bases_left", exp_codes.size(), 0);
        rst = 1'b1;
        exp_ids.delete();
        next_id = '0;
        exp_codes.push_back(2'b11);
        exp_codes.push_back(2'b10);
        exp_ids.push_back(next_id);
        next_id = next_id + 3'd1;
        send_str(">y\n");
        send_str("GA\n");
        count_low(cnt);
        pulse_vld(12'hF00, 13'd1792);

        chk("final_bases_left", exp_codes.size(), 0);
        chk("final_ids_left", exp_ids.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
